// File: rtl/game_state_ctrl_pkg.sv
// Shared types and constants for the game flow controller and the blocks that consume its outputs.
// Downstream logic compares game_active against GM_PLAY rather than a bare literal.
package game_state_ctrl_pkg;

    localparam int DEF_CLK_HZ    = 65_000_000;
    localparam int DEF_FPS       = 60;
    localparam int FRAME_TICKS   = DEF_CLK_HZ / DEF_FPS;
    localparam int FRAME_CNT_W   = 21;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_BOSS_DOWN = 3'd3,
        ST_WIN       = 3'd4,
        ST_LOSE      = 3'd5
    } game_state_t;

    typedef enum logic [1:0] {
        GM_MENU = 2'd0,
        GM_PLAY = 2'd1,
        GM_WIN  = 2'd2,
        GM_LOSE = 2'd3
    } game_mode_t;

    // The HUD stays visible through the dying and boss-down animations.
    function automatic game_mode_t mode_of(game_state_t s);
        case (s)
            ST_PLAYING, ST_DYING, ST_BOSS_DOWN: return GM_PLAY;
            ST_WIN:                             return GM_WIN;
            ST_LOSE:                            return GM_LOSE;
            default:                            return GM_MENU;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Bundle between the game flow controller and its neighbours (button, HUD overlay, boss logic).
// The slave modport is the controller's view; master is the surrounding system.
interface game_state_ctrl_if;
    import game_state_ctrl_pkg::*;

    logic        btn_start;
    logic [3:0]  current_health;
    logic [7:0]  boss_hp;
    game_mode_t  game_active;
    logic        game_start;
    logic        frame_tick;
    game_state_t fsm_state;

    modport master (
        output btn_start, current_health, boss_hp,
        input  game_active, game_start, frame_tick, fsm_state
    );

    modport slave (
        input  btn_start, current_health, boss_hp,
        output game_active, game_start, frame_tick, fsm_state
    );

endinterface

// File: rtl/game_state_ctrl_frame_tick_gen.sv
// Frame tick generator: one-cycle registered pulse every FRAME_TICKS clocks.
// Also intended for the heart overlay and sprite animators.
module game_state_ctrl_frame_tick_gen
    import game_state_ctrl_pkg::*;
#(
    parameter int FRAME_TICKS = game_state_ctrl_pkg::FRAME_TICKS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    if (FRAME_TICKS < 1 || FRAME_TICKS > (1 << FRAME_CNT_W)) begin : g_bad_ticks
        $fatal(1, "FRAME_TICKS out of range for the 21-bit frame counter");
    end

    localparam logic [FRAME_CNT_W-1:0] LAST = FRAME_CNT_W'(FRAME_TICKS - 1);

    logic [FRAME_CNT_W-1:0] cnt_q;
    logic                   tick_q;

    // tick_q rises together with the counter returning to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: menu/play/win/lose sequencing, start-button edge detect, frame-counted delays.
// rst is active-low and asynchronous.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int FPS          = 60,
    parameter int DEATH_FRAMES = 90,
    parameter int WIN_FRAMES   = 60,
    parameter int ARM_FRAMES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    game_state_ctrl_if.slave  gs
);

    localparam int TICKS_PER_FRAME = CLK_HZ / FPS;

    if (DEATH_FRAMES < 1 || DEATH_FRAMES > 255 ||
        WIN_FRAMES   < 1 || WIN_FRAMES   > 255 ||
        ARM_FRAMES   < 1 || ARM_FRAMES   > 255) begin : g_bad_delays
        $fatal(1, "frame delay parameters must lie in 1..255");
    end

    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);
    localparam logic [7:0] ARM_LOAD   = 8'(ARM_FRAMES);

    game_state_t state_q, state_d;
    game_mode_t  game_active_q, game_active_d;
    logic        game_start_q, game_start_d;
    logic        btn_q;
    logic [7:0]  arm_q, arm_d;
    logic [7:0]  dly_q, dly_d;
    logic        frame_tick;
    logic        start_rise;
    logic        checks_en;

    game_state_ctrl_frame_tick_gen #(
        .FRAME_TICKS (TICKS_PER_FRAME)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick)
    );

    assign start_rise = gs.btn_start & ~btn_q;
    // Zero-HP checks wait out the downstream HP reload after game_start.
    assign checks_en  = (arm_q == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_MENU;
            game_active_q <= GM_MENU;
            game_start_q  <= 1'b0;
            btn_q         <= 1'b1;
            arm_q         <= 8'd0;
            dly_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            game_active_q <= game_active_d;
            game_start_q  <= game_start_d;
            btn_q         <= gs.btn_start;
            arm_q         <= arm_d;
            dly_q         <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        dly_d   = dly_q;
        if (frame_tick && arm_q != 8'd0) begin
            arm_d = arm_q - 8'd1;
        end
        case (state_q)
            ST_MENU, ST_WIN, ST_LOSE: begin
                if (start_rise) begin
                    state_d = ST_PLAYING;
                    arm_d   = ARM_LOAD;
                end
            end
            ST_PLAYING: begin
                if (checks_en) begin
                    if (gs.current_health == 4'd0) begin
                        state_d = ST_DYING;
                        dly_d   = 8'd0;
                    end else if (gs.boss_hp == 8'd0) begin
                        state_d = ST_BOSS_DOWN;
                        dly_d   = 8'd0;
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (dly_q == DEATH_LAST) state_d = ST_LOSE;
                    else                     dly_d   = sat_inc(dly_q);
                end
            end
            ST_BOSS_DOWN: begin
                if (frame_tick) begin
                    if (dly_q == WIN_LAST) state_d = ST_WIN;
                    else                   dly_d   = sat_inc(dly_q);
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_comb begin
        game_active_d = mode_of(state_d);
        game_start_d  = (state_d == ST_PLAYING) &&
                        (state_q == ST_MENU || state_q == ST_WIN || state_q == ST_LOSE);
    end

    assign gs.game_active = game_active_q;
    assign gs.game_start  = game_start_q;
    assign gs.frame_tick  = frame_tick;
    assign gs.fsm_state   = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: expected state/mode/start events are queued with the
// stimulus and popped whenever the DUT changes state, changes mode or pulses game_start.
module tb_game_state_ctrl;
    import game_state_ctrl_pkg::*;

    typedef struct {
        game_state_t st;
        game_mode_t  act;
        logic        start;
        int          ticks;   // frame ticks since previous event, -1 = don't care
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   tick_acc = 0;
    exp_t sb[$];
    game_state_t prev_st = ST_MENU;
    game_mode_t  prev_act = GM_MENU;

    game_state_ctrl_if bus();

    game_state_ctrl #(
        .CLK_HZ       (600),
        .FPS          (60),
        .DEATH_FRAMES (3),
        .WIN_FRAMES   (2),
        .ARM_FRAMES   (2)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .gs  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ev(input game_state_t st, input game_mode_t act, input logic start, input int ticks);
        exp_t e;
        e.st = st; e.act = act; e.start = start; e.ticks = ticks;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check_eq(tag, sb.size(), 0);
    endtask

    task automatic press();
        bus.btn_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_start = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Event monitor plus frame tick period check.
    always @(negedge clk) begin
        exp_t e;
        if (bus.fsm_state !== prev_st || bus.game_active !== prev_act || bus.game_start === 1'b1) begin
            $display("event t=%0t state=%0d active=%0d start=%0b ticks=%0d",
                     $time, bus.fsm_state, bus.game_active, bus.game_start, tick_acc);
            check_eq("expected_event", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("ev_state", bus.fsm_state, e.st);
                check_eq("ev_active", bus.game_active, e.act);
                check_eq("ev_start", bus.game_start, e.start);
                if (e.ticks >= 0) check_eq("ev_ticks", tick_acc, e.ticks);
            end
            tick_acc = (bus.frame_tick === 1'b1) ? 1 : 0;
        end else if (bus.frame_tick === 1'b1) begin
            tick_acc++;
        end
        prev_st  = bus.fsm_state;
        prev_act = bus.game_active;
        if (rst_n && (bus.frame_tick === 1'b1 || (cyc != 0 && cyc % 10 == 0)))
            check_eq("tick_period", bus.frame_tick, 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_start      = 1'b1;
        bus.current_health = 4'd5;
        bus.boss_hp        = 8'd100;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_active", bus.game_active, GM_MENU);
        check_eq("rst_start", bus.game_start, 0);
        check_eq("rst_tick", bus.frame_tick, 0);
        check_eq("rst_state", bus.fsm_state, ST_MENU);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Button held through reset release must not start a game.
        repeat (20) @(negedge clk);
        check_eq("held_no_start", bus.game_active, GM_MENU);

        // Start with zero health: arm window holds PLAYING for 2 ticks, then DYING, LOSE after 3.
        bus.current_health = 4'd0;
        expect_ev(ST_PLAYING, GM_PLAY, 1'b1, -1);
        expect_ev(ST_DYING,   GM_PLAY, 1'b0, 2);
        expect_ev(ST_LOSE,    GM_LOSE, 1'b0, 3);
        press();
        wait_drain("drain_first_game", 200);

        // Restart from LOSE, then boss defeat -> BOSS_DOWN -> WIN after 2 ticks.
        bus.current_health = 4'd5;
        expect_ev(ST_PLAYING, GM_PLAY, 1'b1, -1);
        press();
        wait_drain("drain_restart_lose", 20);
        press();
        repeat (25) @(negedge clk);
        expect_ev(ST_BOSS_DOWN, GM_PLAY, 1'b0, -1);
        expect_ev(ST_WIN,       GM_WIN,  1'b0, 2);
        bus.boss_hp = 8'd0;
        wait_drain("drain_boss_down", 100);

        // Restart from WIN; zero health and zero boss in the same cycle -> DYING path wins.
        bus.boss_hp = 8'd100;
        expect_ev(ST_PLAYING, GM_PLAY, 1'b1, -1);
        press();
        wait_drain("drain_restart_win", 20);
        repeat (30) @(negedge clk);
        expect_ev(ST_DYING, GM_PLAY, 1'b0, -1);
        expect_ev(ST_LOSE,  GM_LOSE, 1'b0, 3);
        bus.current_health = 4'd0;
        bus.boss_hp        = 8'd0;
        wait_drain("drain_simultaneous", 100);

        // Restart from LOSE with zero health: arm counter must be reloaded.
        bus.boss_hp = 8'd50;
        expect_ev(ST_PLAYING, GM_PLAY, 1'b1, -1);
        expect_ev(ST_DYING,   GM_PLAY, 1'b0, 2);
        press();
        wait_drain("drain_rearm", 100);

        // Reset in the middle of DYING.
        bus.btn_start = 1'b0;
        repeat (5) @(negedge clk);
        expect_ev(ST_MENU, GM_MENU, 1'b0, -1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_active", bus.game_active, GM_MENU);
        check_eq("midrst_start", bus.game_start, 0);
        check_eq("midrst_tick", bus.frame_tick, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_drain("drain_reset", 5);
        repeat (35) @(negedge clk);
        check_eq("post_rst_menu", bus.fsm_state, ST_MENU);
        check_eq("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
